miter_stim_driver: RTL and testbench

//  Drives primary-input vectors into an equivalence miter and collects its gold/gate output pairs.

---
 rtl/miter_stim_driver.sv | 122 ++++++++++++
 tb/tb_miter_stim_driver.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/miter_stim_driver.sv
// Stimulus driver for an equivalence miter: issues LFSR-generated PI vectors,
// compares gold/gate responses, counts failures and latches the first failing vector.
module miter_stim_driver #(
  parameter int unsigned PI_WIDTH     = 1,
  parameter int unsigned PO_WIDTH     = 1,
  parameter logic [31:0] LFSR_SEED    = 32'h00000001,
  parameter int unsigned NUM_VECTORS  = 256,
  parameter int unsigned RESP_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [PI_WIDTH-1:0] pi_data,
  output logic                pi_valid,
  input  logic                pi_ready,
  input  logic                po_valid,
  input  logic [PO_WIDTH-1:0] po_gold,
  input  logic [PO_WIDTH-1:0] po_gate,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [15:0]         fail_count,
  output logic [15:0]         first_fail_idx,
  output logic [PI_WIDTH-1:0] first_fail_vec
);

  localparam logic [31:0] SEED     = (LFSR_SEED == '0) ? 32'd1 : LFSR_SEED;
  localparam logic [7:0]  TMO_LAST = 8'(RESP_TIMEOUT - 1);
  localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT, S_DONE} state_t;

  state_t      state;
  logic [31:0] lfsr;
  logic [15:0] idx;
  logic [7:0]  wait_cnt;
  logic        resp_done;
  logic        resp_fail;

  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    return cur[0] ? ((cur >> 1) ^ 32'h80200003) : (cur >> 1);
  endfunction

  // The last WAIT cycle resolves the vector either way; a po_valid there wins over the timeout.
  always_comb begin
    resp_done = po_valid || (wait_cnt == TMO_LAST);
    resp_fail = po_valid ? (po_gold != po_gate) : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_IDLE;
      lfsr           <= SEED;
      idx            <= '0;
      wait_cnt       <= '0;
      pi_data        <= '0;
      pi_valid       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      first_fail_vec <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_DRIVE;
            lfsr           <= SEED;
            idx            <= '0;
            pi_data        <= SEED[PI_WIDTH-1:0];
            pi_valid       <= 1'b1;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            first_fail_vec <= '0;
          end
        end
        S_DRIVE: begin
          if (pi_ready) begin
            state    <= S_WAIT;
            pi_valid <= 1'b0;
            lfsr     <= lfsr_next(lfsr);
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (!resp_done) begin
            wait_cnt <= wait_cnt + 8'd1;
          end else begin
            if (!po_valid) timeout <= 1'b1;
            if (resp_fail) begin
              if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
              if (fail_count == '0) begin
                first_fail_idx <= idx;
                first_fail_vec <= pi_data;
              end
            end
            idx <= idx + 16'd1;
            if (idx == LAST_IDX) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= !resp_fail && (fail_count == '0);
            end else begin
              state    <= S_DRIVE;
              pi_valid <= 1'b1;
              pi_data  <= lfsr[PI_WIDTH-1:0];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_miter_stim_driver.sv
// Self-checking bench for miter_stim_driver: a miter responder with random handshake and
// response delays, checked against an LFSR/scoreboard reference model.
module tb_miter_stim_driver;

  localparam int unsigned NV  = 8;
  localparam int unsigned TMO = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] pi_data;
  logic        pi_valid;
  logic        pi_ready;
  logic        po_valid;
  logic [7:0]  po_gold;
  logic [7:0]  po_gate;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [15:0] fail_count;
  logic [15:0] first_fail_idx;
  logic [31:0] first_fail_vec;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] m_lfsr;
  int          m_fail;
  bit          m_timeout;
  int          m_first_idx;
  logic [31:0] m_first_vec;

  miter_stim_driver #(
    .PI_WIDTH(32), .PO_WIDTH(8), .LFSR_SEED(32'h00000001),
    .NUM_VECTORS(NV), .RESP_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .pi_data(pi_data), .pi_valid(pi_valid), .pi_ready(pi_ready),
    .po_valid(po_valid), .po_gold(po_gold), .po_gate(po_gate),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .fail_count(fail_count), .first_fail_idx(first_fail_idx), .first_fail_vec(first_fail_vec)
  );

  always #5 clk = ~clk;

  // Galois right-shift LFSR step, taken straight from the polynomial rule.
  function automatic logic [31:0] ref_next(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h80200003) : (x >> 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic record_fail(input int v, input logic [31:0] vec);
    if (m_fail == 0) begin
      m_first_idx = v;
      m_first_vec = vec;
    end
    m_fail++;
  endtask

  // mode 0: responses; mode 1: never respond. abort_at >= 0 stops right after that handshake.
  task automatic run(input int mode, input logic [7:0] mis_mask, input bit rand_ready,
                     input bit rand_dly, input int abort_at);
    int rd;
    int d;
    logic [31:0] vec;
    m_lfsr = 32'h1; m_fail = 0; m_timeout = 0; m_first_idx = 0; m_first_vec = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("done_drop", {31'b0, done}, 32'd0);
    chk("busy_start", {31'b0, busy}, 32'd1);
    chk("fail_clr", {16'b0, fail_count}, 32'd0);
    for (int v = 0; v < int'(NV); v++) begin
      chk("pi_valid", {31'b0, pi_valid}, 32'd1);
      chk("pi_data", pi_data, m_lfsr);
      rd = !rand_ready ? 0 : (v == 0) ? 4 : (v == 3) ? 1 + int'($urandom_range(0, 1))
                                                  : int'($urandom_range(0, 2));
      for (int k = 0; k < rd; k++) begin
        pi_ready = 1'b0;
        start    = (v == 3 && k == 0);
        po_valid = 1'b1;      // stray responses outside WAIT must not count
        po_gold  = 8'h00;
        po_gate  = 8'hFF;
        step();
        start = 1'b0;
        chk("hold_valid", {31'b0, pi_valid}, 32'd1);
        chk("hold_data", pi_data, m_lfsr);
        chk("hold_busy", {31'b0, busy}, 32'd1);
      end
      po_valid = 1'b0;
      pi_ready = 1'b1;
      step();
      pi_ready = 1'b0;
      chk("wait_valid", {31'b0, pi_valid}, 32'd0);
      vec    = m_lfsr;
      m_lfsr = ref_next(m_lfsr);
      if (v == abort_at) return;
      if (mode == 1) begin
        step();
        step();
        chk("tmo_waiting", {31'b0, pi_valid}, 32'd0);
        step();
        m_timeout = 1;
        record_fail(v, vec);
      end else begin
        d = rand_dly ? int'($urandom_range(0, TMO - 1)) : 0;
        for (int k = 0; k < d; k++) begin
          step();
          chk("resp_waiting", {31'b0, pi_valid}, 32'd0);
        end
        po_valid = 1'b1;
        po_gold  = 8'($urandom);
        po_gate  = mis_mask[v] ? po_gold ^ 8'($urandom_range(1, 255)) : po_gold;
        step();
        po_valid = 1'b0;
        if (mis_mask[v]) record_fail(v, vec);
      end
      chk("fail_run", {16'b0, fail_count}, 32'(m_fail));
    end
    chk("done", {31'b0, done}, 32'd1);
    chk("busy_end", {31'b0, busy}, 32'd0);
    chk("pass", {31'b0, pass}, 32'(m_fail == 0));
    chk("timeout", {31'b0, timeout}, 32'(m_timeout));
    chk("first_idx", {16'b0, first_fail_idx}, 32'(m_first_idx));
    chk("first_vec", first_fail_vec, m_first_vec);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out"}, {25'b0, pi_valid, busy, done, pass, timeout, |pi_data, |first_fail_vec}, 32'd0);
    chk({tag, "_cnt"}, {fail_count, first_fail_idx}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; pi_ready = 1'b0; po_valid = 1'b0; po_gold = '0; po_gate = '0;
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b1;
    step();
    chk_all_zero("idle");

    run(0, 8'h00, 1'b0, 1'b0, -1);              // clean run, back-to-back vectors
    run(0, 8'h20, 1'b1, 1'b1, -1);              // single mismatch on vector 5, stalls, busy start
    run(0, 8'($urandom), 1'b1, 1'b1, -1);       // random mismatches
    run(1, 8'h00, 1'b0, 1'b0, -1);              // every response times out
    run(0, 8'h00, 1'b0, 1'b1, 3);               // abandon during WAIT of vector 3
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk_all_zero("midrun_rst");
    step();
    chk_all_zero("post_rst");
    run(0, 8'h00, 1'b0, 1'b1, -1);              // restart from the seed

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
